diagv2_ecall_unit: RTL and testbench
====================================

Name: diagv2_ecall_unit

Overview:
- Environment-call service block directly downstream of the core's `ecall` output.
- On an ecall it samples a7 (service ID) and a0 (argument), stalls the core while serving, and either:
  - serialises console bytes over a valid/ready byte stream, or
  - latches the EXIT status and halts permanently.
- Replaces bench-side ecall handling so self-checking programs can run on silicon/FPGA.

Parameters:
- DATA_W, 64, width of a7/a0 operands (matches core data bus).
- SYS_EXIT, 93, service ID for program exit.
- SYS_PUTC, 11, service ID: print one character (a0[7:0]).
- SYS_PUTD, 1, service ID: dump a0 as DATA_W/8 raw bytes, LSB first.
- TIMEOUT, 1024, tx stall cycles before abandon (optional feature only).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ecall  in  1  core is executing an ECALL this cycle.
- sys_id  in  DATA_W  a7/x17 value.
- sys_arg  in  DATA_W  a0/x10 value.
- stall  out  1  hold core PC/writeback (combinational).
- tx_data  out  8  console byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte.
- halted  out  1  EXIT executed; core frozen.
- exit_code  out  DATA_W  latched a0 at EXIT.
- bad_ecall  out  1  one-cycle pulse: unrecognised service ID.
- ecall_count  out  16  recognised ecalls served, saturating.
- tx_timeout  out  1  one-cycle pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (async, any state): state=IDLE; tx_valid=0, tx_data=0, halted=0, exit_code=0, bad_ecall=0, ecall_count=0, byte counter=0, shift register=0.
- States:
  - IDLE: default state.
  - SEND: serialising bytes.
  - ACK: one-cycle release.
  - HALT: terminal.
- stall = (state==SEND) | (state==HALT) | (state==IDLE & ecall & sys_id ∈ {EXIT,PUTC,PUTD}). ACK drives stall=0 so the core retires the ECALL on that edge.
- IDLE, ecall=1 at rising edge:
  - sys_id==SYS_EXIT → exit_code<=sys_arg, halted<=1, go HALT, ecall_count++.
  - sys_id==SYS_PUTC → shift<=sys_arg[7:0], count<=1, go SEND, ecall_count++.
  - sys_id==SYS_PUTD → shift<=sys_arg, count<=DATA_W/8, go SEND, ecall_count++.
  - any other ID → bad_ecall=1 for one cycle, stay IDLE, stall=0 (core skips the ECALL).
- IDLE, ecall=0 → no change.
- SEND:
  - tx_valid=1, tx_data=shift[7:0]; both stable until handshake.
  - On tx_valid&tx_ready: shift>>=8, count--.
  - If count was 1 → tx_valid<=0, go ACK.
  - tx_ready high continuously gives 1 byte/cycle.
- ACK: ecall is ignored (the core is still on the ECALL instruction this cycle); go IDLE next edge.
- HALT: terminal. stall=1 and halted=1 until reset; ecall and tx_ready are ignored.
- ecall_count saturates at 0xFFFF.
- Back-to-back ECALLs: the earliest re-trigger is the cycle after ACK.
- Latency:
  - PUTC: 1 cycle to tx_valid; stall released 1 cycle after the final handshake.
  - EXIT: halted visible the cycle after ecall sampled.

Optional Feature:
- Macro DIAGV2_ECALL_TIMEOUT_EN.
- Defined:
  - A counter increments each SEND cycle with tx_valid&!tx_ready.
  - The counter clears on handshake and on entry to SEND.
  - On reaching TIMEOUT: remaining bytes are dropped, tx_valid<=0, tx_timeout pulses 1 cycle, go ACK.
- Undefined: no counter; SEND waits indefinitely; tx_timeout tied 0.

Test Plan:
- ecall, sys_id=93, sys_arg=0 → stall combinational high same cycle; next cycle halted=1, exit_code=0, ecall_count=1; ecall toggling afterward → no change until reset.
- ecall, sys_id=11, sys_arg=0x41, tx_ready=1 → single byte 0x41 with tx_valid for 1 cycle, ACK cycle stall=0, back to IDLE; ecall held high through ACK → no second byte.
- ecall, sys_id=1, sys_arg=0x0807060504030201, tx_ready toggling 1/0 → bytes 01..08 in order, tx_data stable while !tx_ready, exactly 8 handshakes.
- ecall, sys_id=42 → bad_ecall one-cycle pulse, stall=0, ecall_count unchanged.
- Assert reset mid-SEND after 3 of 8 bytes → all outputs zero immediately (async); subsequent PUTC 0x5A emits only 0x5A.
- DIAGV2_ECALL_TIMEOUT_EN, TIMEOUT=16, PUTD with tx_ready=0 → tx_timeout pulse after 16 stalled cycles, ACK, IDLE; undefined → tx_valid held ≥100 cycles.

Source files
------------

// File: rtl/diagv2_ecall_unit.sv
// Environment-call service unit: serves EXIT / PUTC / PUTD ecalls from the core.
// Optional stalled-sink abandon logic is enabled by defining DIAGV2_ECALL_TIMEOUT_EN.
module diagv2_ecall_unit #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned SYS_EXIT = 93,
    parameter int unsigned SYS_PUTC = 11,
    parameter int unsigned SYS_PUTD = 1,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              ecall_i,
    input  logic [DATA_W-1:0] sys_id_i,
    input  logic [DATA_W-1:0] sys_arg_i,
    output logic              stall_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              halted_o,
    output logic [DATA_W-1:0] exit_code_o,
    output logic              bad_ecall_o,
    output logic [15:0]       ecall_count_o,
    output logic              tx_timeout_o
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2,
        HALT = 2'd3
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   shift_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                tx_valid_q;
    logic                halted_q;
    logic [DATA_W-1:0]   exit_code_q;
    logic                bad_q;
    logic [15:0]         ecall_count_q;
    logic [15:0]         ecall_count_d;

    logic is_exit, is_putc, is_putd, known_id, hshake;

    assign is_exit  = (sys_id_i == DATA_W'(SYS_EXIT));
    assign is_putc  = (sys_id_i == DATA_W'(SYS_PUTC));
    assign is_putd  = (sys_id_i == DATA_W'(SYS_PUTD));
    assign known_id = is_exit | is_putc | is_putd;
    assign hshake   = tx_valid_q & tx_ready_i;

    // Saturating service counter.
    assign ecall_count_d = (ecall_count_q == 16'hFFFF) ? ecall_count_q : ecall_count_q + 16'd1;

    // Stall must be combinational so the core freezes in the ecall cycle itself.
    assign stall_o = (state_q == SEND) | (state_q == HALT) |
                     ((state_q == IDLE) & ecall_i & known_id);

`ifdef DIAGV2_ECALL_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_pulse_q;
    assign tx_timeout_o = tmo_pulse_q;
`else
    assign tx_timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            cnt_q         <= '0;
            tx_valid_q    <= 1'b0;
            halted_q      <= 1'b0;
            exit_code_q   <= '0;
            bad_q         <= 1'b0;
            ecall_count_q <= '0;
`ifdef DIAGV2_ECALL_TIMEOUT_EN
            tmo_q         <= '0;
            tmo_pulse_q   <= 1'b0;
`endif
        end else begin
            bad_q <= 1'b0;
`ifdef DIAGV2_ECALL_TIMEOUT_EN
            tmo_pulse_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (ecall_i) begin
                        if (is_exit) begin
                            exit_code_q   <= sys_arg_i;
                            halted_q      <= 1'b1;
                            ecall_count_q <= ecall_count_d;
                            state_q       <= HALT;
                        end else if (is_putc) begin
                            shift_q       <= DATA_W'(sys_arg_i[7:0]);
                            cnt_q         <= CNT_W'(1);
                            tx_valid_q    <= 1'b1;
                            ecall_count_q <= ecall_count_d;
                            state_q       <= SEND;
`ifdef DIAGV2_ECALL_TIMEOUT_EN
                            tmo_q         <= '0;
`endif
                        end else if (is_putd) begin
                            shift_q       <= sys_arg_i;
                            cnt_q         <= CNT_W'(NBYTES);
                            tx_valid_q    <= 1'b1;
                            ecall_count_q <= ecall_count_d;
                            state_q       <= SEND;
`ifdef DIAGV2_ECALL_TIMEOUT_EN
                            tmo_q         <= '0;
`endif
                        end else begin
                            bad_q <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (hshake) begin
                        shift_q <= shift_q >> 8;
                        cnt_q   <= cnt_q - CNT_W'(1);
`ifdef DIAGV2_ECALL_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                        if (cnt_q == CNT_W'(1)) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= ACK;
                        end
                    end
`ifdef DIAGV2_ECALL_TIMEOUT_EN
                    // Sink stuck: drop whatever is left and release the core.
                    else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        shift_q     <= '0;
                        cnt_q       <= '0;
                        tmo_q       <= '0;
                        tx_valid_q  <= 1'b0;
                        tmo_pulse_q <= 1'b1;
                        state_q     <= ACK;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
`endif
                end
                // Core retires the ECALL during ACK, so ecall is not sampled here.
                ACK:     state_q <= IDLE;
                HALT:    state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data_o     = shift_q[7:0];
    assign tx_valid_o    = tx_valid_q;
    assign halted_o      = halted_q;
    assign exit_code_o   = exit_code_q;
    assign bad_ecall_o   = bad_q;
    assign ecall_count_o = ecall_count_q;

endmodule

// File: tb/tb_diagv2_ecall_unit.sv
// Directed bench for diagv2_ecall_unit; DUT built with TIMEOUT=16.
module tb_diagv2_ecall_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ecall = 1'b0;
    logic [63:0] sys_id = '0;
    logic [63:0] sys_arg = '0;
    logic        tx_ready = 1'b0;
    logic        stall;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        halted;
    logic [63:0] exit_code;
    logic        bad_ecall;
    logic [15:0] ecall_count;
    logic        tx_timeout;

    int total = 0;
    int bad = 0;
    logic [7:0] rxq[$];

    diagv2_ecall_unit #(.DATA_W(64), .TIMEOUT(16)) dut (
        .clk_i(clk), .reset_i(reset), .ecall_i(ecall), .sys_id_i(sys_id),
        .sys_arg_i(sys_arg), .stall_o(stall), .tx_data_o(tx_data),
        .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .halted_o(halted),
        .exit_code_o(exit_code), .bad_ecall_o(bad_ecall),
        .ecall_count_o(ecall_count), .tx_timeout_o(tx_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!reset && tx_valid && tx_ready) rxq.push_back(tx_data);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        total++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || halted !== 1'b0 || exit_code !== 64'h0 ||
            bad_ecall !== 1'b0 || ecall_count !== 16'h0 || stall !== 1'b0 || tx_timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: valid=%b data=%h halted=%b code=%h bad=%b cnt=%h stall=%b, need all zero",
                     tx_valid, tx_data, halted, exit_code, bad_ecall, ecall_count, stall);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_putc();
        rxq.delete();
        ecall = 1'b1; sys_id = 64'd11; sys_arg = 64'h41; tx_ready = 1'b1;
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL putc_stall_comb: got %b need 1", stall); end
        tick();
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h41 || stall !== 1'b1 || ecall_count !== 16'd1) begin
            bad++;
            $display("FAIL putc_send: valid=%b data=%h stall=%b cnt=%0d need 1 41 1 1", tx_valid, tx_data, stall, ecall_count);
        end
        tick();
        total++;
        if (tx_valid !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL putc_ack: valid=%b stall=%b need 0 0", tx_valid, stall);
        end
        tick();
        ecall = 1'b0;
        tick();
        tick();
        total++;
        if (rxq.size() != 1 || rxq[0] !== 8'h41 || tx_valid !== 1'b0 || ecall_count !== 16'd1) begin
            bad++;
            $display("FAIL putc_bytes: n=%0d valid=%b cnt=%0d need one byte 41, valid 0, cnt 1", rxq.size(), tx_valid, ecall_count);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_putd_toggle();
        logic [7:0] held;
        logic       hv;
        bit         done = 0;
        rxq.delete();
        ecall = 1'b1; sys_id = 64'd1; sys_arg = 64'h0807060504030201; tx_ready = 1'b0;
        tick();
        ecall = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (!stall) begin done = 1; break; end
            tx_ready = cyc[0];
            held = tx_data;
            hv = tx_valid;
            tick();
            if (!tx_ready && hv) begin
                total++;
                if (tx_valid !== 1'b1 || tx_data !== held) begin
                    bad++; $display("FAIL putd_hold: valid=%b data=%h need 1 %h", tx_valid, tx_data, held);
                end
            end
        end
        tx_ready = 1'b0;
        total++;
        if (!done) begin bad++; $display("FAIL putd_release: stall still %b after 40 cycles, need 0", stall); end
        tick();
        total++;
        if (rxq.size() != 8) begin
            bad++; $display("FAIL putd_count: got %0d handshakes need 8", rxq.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (rxq[i] !== 8'(i + 1)) begin
                    bad++; $display("FAIL putd_byte%0d: got %h need %h", i, rxq[i], 8'(i + 1));
                end
            end
        end
        total++;
        if (ecall_count !== 16'd2) begin bad++; $display("FAIL putd_ecall_count: got %0d need 2", ecall_count); end
    endtask

    task automatic test_bad_id();
        ecall = 1'b1; sys_id = 64'd42; sys_arg = 64'h5;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL bad_stall: got %b need 0", stall); end
        tick();
        ecall = 1'b0;
        total++;
        if (bad_ecall !== 1'b1 || ecall_count !== 16'd2 || tx_valid !== 1'b0) begin
            bad++; $display("FAIL bad_pulse: bad=%b cnt=%0d valid=%b need 1 2 0", bad_ecall, ecall_count, tx_valid);
        end
        tick();
        total++;
        if (bad_ecall !== 1'b0) begin bad++; $display("FAIL bad_pulse_len: got %b need 0", bad_ecall); end
    endtask

    task automatic test_timeout();
        bit ok = 1;
        rxq.delete();
        ecall = 1'b1; sys_id = 64'd1; sys_arg = 64'h1122334455667788; tx_ready = 1'b0;
        tick();
        ecall = 1'b0;
`ifdef DIAGV2_ECALL_TIMEOUT_EN
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (tx_valid !== 1'b1 || tx_timeout !== 1'b0 || stall !== 1'b1) ok = 0;
        end
        total++;
        if (!ok) begin bad++; $display("FAIL tmo_early: valid=%b tmo=%b stall=%b need 1 0 1", tx_valid, tx_timeout, stall); end
        tick();
        total++;
        if (tx_timeout !== 1'b1 || tx_valid !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL tmo_pulse: tmo=%b valid=%b stall=%b need 1 0 0", tx_timeout, tx_valid, stall);
        end
        tick();
        total++;
        if (tx_timeout !== 1'b0 || tx_valid !== 1'b0 || stall !== 1'b0 || rxq.size() != 0) begin
            bad++; $display("FAIL tmo_idle: tmo=%b valid=%b stall=%b n=%0d need 0 0 0 0", tx_timeout, tx_valid, stall, rxq.size());
        end
`else
        for (int i = 0; i < 110; i++) begin
            tick();
            if (tx_valid !== 1'b1 || tx_data !== 8'h88 || stall !== 1'b1 || tx_timeout !== 1'b0) ok = 0;
        end
        total++;
        if (!ok) begin bad++; $display("FAIL no_tmo_hold: valid=%b data=%h stall=%b need 1 88 1", tx_valid, tx_data, stall); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
`endif
    endtask

    task automatic test_reset_mid_send();
        rxq.delete();
        ecall = 1'b1; sys_id = 64'd1; sys_arg = 64'h0807060504030201; tx_ready = 1'b1;
        tick();
        ecall = 1'b0;
        tick(); tick(); tick();
        total++;
        if (tx_data !== 8'h04 || tx_valid !== 1'b1 || rxq.size() != 3) begin
            bad++; $display("FAIL mid_pre: data=%h valid=%b n=%0d need 04 1 3", tx_data, tx_valid, rxq.size());
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || stall !== 1'b0 || halted !== 1'b0 || ecall_count !== 16'd0) begin
            bad++; $display("FAIL mid_async_reset: valid=%b data=%h stall=%b halted=%b cnt=%0d need all 0",
                            tx_valid, tx_data, stall, halted, ecall_count);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        rxq.delete();
        ecall = 1'b1; sys_id = 64'd11; sys_arg = 64'hFFFF_FFFF_FFFF_FF5A;
        tick();
        ecall = 1'b0;
        total++;
        if (tx_data !== 8'h5A || tx_valid !== 1'b1) begin
            bad++; $display("FAIL mid_putc_send: data=%h valid=%b need 5a 1", tx_data, tx_valid);
        end
        tick(); tick(); tick();
        total++;
        if (rxq.size() != 1 || rxq[0] !== 8'h5A || ecall_count !== 16'd1) begin
            bad++; $display("FAIL mid_putc_bytes: n=%0d cnt=%0d need one byte 5a, cnt 1", rxq.size(), ecall_count);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_exit();
        bit ok = 1;
        ecall = 1'b1; sys_id = 64'd93; sys_arg = 64'h0;
        #1;
        total++;
        if (stall !== 1'b1 || halted !== 1'b0) begin
            bad++; $display("FAIL exit_stall_comb: stall=%b halted=%b need 1 0", stall, halted);
        end
        tick();
        ecall = 1'b0;
        total++;
        if (halted !== 1'b1 || exit_code !== 64'h0 || ecall_count !== 16'd2 || stall !== 1'b1) begin
            bad++; $display("FAIL exit_halt: halted=%b code=%h cnt=%0d stall=%b need 1 0 2 1", halted, exit_code, ecall_count, stall);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ecall = i[0];
            sys_id = i[1] ? 64'd11 : 64'd42;
            sys_arg = 64'h77;
            tick();
            if (halted !== 1'b1 || stall !== 1'b1 || tx_valid !== 1'b0 || bad_ecall !== 1'b0 ||
                ecall_count !== 16'd2 || exit_code !== 64'h0) ok = 0;
        end
        ecall = 1'b0; tx_ready = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL exit_frozen: halted=%b stall=%b valid=%b cnt=%0d need 1 1 0 2", halted, stall, tx_valid, ecall_count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (halted !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL exit_reset: halted=%b stall=%b need 0 0", halted, stall); end
        ecall = 1'b1; sys_id = 64'd93; sys_arg = 64'hDEAD_BEEF_CAFE_0042;
        tick();
        ecall = 1'b0;
        total++;
        if (halted !== 1'b1 || exit_code !== 64'hDEAD_BEEF_CAFE_0042 || ecall_count !== 16'd1) begin
            bad++; $display("FAIL exit_code: halted=%b code=%h cnt=%0d need 1 deadbeefcafe0042 1", halted, exit_code, ecall_count);
        end
    endtask

    initial begin
        test_reset();
        test_putc();
        test_putd_toggle();
        test_bad_id();
        test_timeout();
        test_reset_mid_send();
        test_exit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
